// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// primary opcodes, ALU operation classes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ADDI_EX  = 4'd8,
    S_ADDI_WB  = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_op_decode.sv
// Combinational opcode classifier: exactly one of the class outputs is high
// for any opcode, with is_illegal catching everything unsupported.
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_addi,
  output logic       is_beq,
  output logic       is_j,
  output logic       is_illegal
);

  always_comb begin
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_addi    = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: is_rtype   = 1'b1;
      OP_LW:    is_lw      = 1'b1;
      OP_SW:    is_sw      = 1'b1;
      OP_ADDI:  is_addi    = 1'b1;
      OP_BEQ:   is_beq     = 1'b1;
      OP_J:     is_j       = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and decodes datapath controls from the current state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_reg;
  logic   illegal_reg;
  logic   pc_write, pc_write_cond;
  logic   is_rtype, is_lw, is_sw, is_addi, is_beq, is_j, is_illegal;

  mips_op_decode u_op_decode (
    .opcode     (opcode),
    .is_rtype   (is_rtype),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_addi    (is_addi),
    .is_beq     (is_beq),
    .is_j       (is_j),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      if (state_reg == S_DECODE && is_illegal)
        illegal_reg <= 1'b1;
      case (state_reg)
        S_FETCH:    if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          if (is_rtype)            state_reg <= S_EXEC;
          else if (is_lw || is_sw) state_reg <= S_MEM_ADDR;
          else if (is_addi)        state_reg <= S_ADDI_EX;
          else if (is_beq)         state_reg <= S_BRANCH;
          else if (is_j)           state_reg <= S_JUMP;
          else                     state_reg <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end
        S_EXEC:     state_reg <= S_R_WB;
        S_MEM_ADDR: state_reg <= is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_reg <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_reg <= S_FETCH;
        S_ADDI_EX:  state_reg <= S_ADDI_WB;
        S_TRAP:     state_reg <= S_TRAP;
        default:    state_reg <= S_FETCH;
      endcase
    end
  end

  // Output decode is combinational on the state register so that the
  // mem_ready-qualified strobes land in the same cycle the memory completes.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH2;
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en      = pc_write | (pc_write_cond & zero);
  assign illegal_op = illegal_reg & rst_n;
  assign state      = state_reg;

endmodule
